bit_serializer: RTL and testbench

Parallel-to-serial feeder that drives the single-bit `X` input of the sequence generator. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock. Between words it drives a programmable idle level, and an optional hold input stalls the stream. Its `x_out`/`x_valid` outputs sit directly upstream of the generator's `X` input, so directed bit patterns can be replayed into the generator from a word-oriented source.

---
 rtl/bit_serializer_if.sv | 24 ++
 rtl/bit_serializer.sv | 79 +++++++
 tb/tb_bit_serializer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle for the bit serializer.
// The upstream word source uses the master modport; the serializer uses slave.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             hold;
  logic             x_out;
  logic             x_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, din_valid, hold,
    input  din_ready, x_out, x_valid, last, busy
  );

  modport slave (
    input  din, din_valid, hold,
    output din_ready, x_out, x_valid, last, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts a WIDTH-bit word and shifts it out one bit per clock,
// driving IDLE_LEVEL between words. Hold stalls the stream in place.
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  bit_serializer_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             at_last;
  logic             in_shift;
  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] sr_shifted;
  logic             head_bit;

  assign in_shift = (state_q == ST_SHIFT);
  assign at_last  = (cnt_q == CW'(WIDTH - 1));

  // The final bit of a word doubles as the accept slot for the next word, giving gapless streaming.
  assign ready  = !rst && (!in_shift || (at_last && !bus.hold));
  assign accept = bus.din_valid && ready;

  assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
  assign head_bit   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (!in_shift) begin
      if (accept) begin
        sr_d    = bus.din;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
    end else if (!bus.hold) begin
      if (!at_last) begin
        sr_d  = sr_shifted;
        cnt_d = cnt_q + CW'(1);
      end else if (accept) begin
        sr_d  = bus.din;
        cnt_d = '0;
      end else begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.din_ready = ready;
  assign bus.x_out     = in_shift ? head_bit : IDLE_LEVEL;
  assign bus.x_valid   = in_shift && !bus.hold;
  assign bus.last      = in_shift && at_last && !bus.hold;
  assign bus.busy      = in_shift;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an 8-bit MSB-first instance and a 4-bit LSB-first
// instance with idle level 0, checked cycle by cycle against hand-computed bit streams.
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) ifa ();
  bit_serializer_if #(.WIDTH(4)) ifb ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [10:0] hold_pat;
    logic [10:0] hold_exp;

    ifa.din = '0; ifa.din_valid = 1'b0; ifa.hold = 1'b0;
    ifb.din = '0; ifb.din_valid = 1'b0; ifb.hold = 1'b0;

    // Reset: ready is forced low while rst is high
    tick(); tick();
    #1;
    check("rst_ready_a", 32'(ifa.din_ready), 32'd0);
    check("rst_ready_b", 32'(ifb.din_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_xout_a", 32'(ifa.x_out), 32'd1);
    check("idle_xout_b", 32'(ifb.x_out), 32'd0);
    check("idle_valid_a", 32'(ifa.x_valid), 32'd0);
    check("idle_busy_a", 32'(ifa.busy), 32'd0);
    check("idle_last_a", 32'(ifa.last), 32'd0);
    check("idle_ready_a", 32'(ifa.din_ready), 32'd1);

    // First word, MSB first
    w0 = 8'b1011_0010;
    ifa.din = w0; ifa.din_valid = 1'b1;
    tick();
    ifa.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      $display("[TB] word1 bit %0d x_out=%0b x_valid=%0b last=%0b", i, ifa.x_out, ifa.x_valid, ifa.last);
      check("w1_xout", 32'(ifa.x_out), 32'(w0[7-i]));
      check("w1_valid", 32'(ifa.x_valid), 32'd1);
      check("w1_last", 32'(ifa.last), 32'(i == 7));
      tick();
    end
    #1;
    check("w1_end_xout", 32'(ifa.x_out), 32'd1);
    check("w1_end_busy", 32'(ifa.busy), 32'd0);
    check("w1_end_valid", 32'(ifa.x_valid), 32'd0);

    // Back-to-back words with no gap bit
    w0 = 8'hF0;
    w1 = 8'h0F;
    ifa.din = w0; ifa.din_valid = 1'b1;
    tick();
    ifa.din = w1;
    for (int i = 0; i < 16; i++) begin
      #1;
      $display("[TB] b2b bit %0d x_out=%0b x_valid=%0b din_ready=%0b", i, ifa.x_out, ifa.x_valid, ifa.din_ready);
      check("b2b_xout", 32'(ifa.x_out), (i < 8) ? 32'(w0[7-i]) : 32'(w1[15-i]));
      check("b2b_valid", 32'(ifa.x_valid), 32'd1);
      check("b2b_ready", 32'(ifa.din_ready), 32'((i % 8) == 7));
      check("b2b_last", 32'(ifa.last), 32'((i % 8) == 7));
      tick();
      if (i == 7) ifa.din_valid = 1'b0;
    end
    #1;
    check("b2b_end_valid", 32'(ifa.x_valid), 32'd0);

    // Hold for 3 cycles while the 3rd bit of 8'hA5 is on the line
    hold_pat = 11'b000_0001_1100;
    hold_exp = 11'b101_0011_1101;
    ifa.din = 8'hA5; ifa.din_valid = 1'b1;
    tick();
    ifa.din_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ifa.hold = hold_pat[i];
      #1;
      $display("[TB] hold cycle %0d hold=%0b x_out=%0b x_valid=%0b", i, ifa.hold, ifa.x_out, ifa.x_valid);
      check("hold_xout", 32'(ifa.x_out), 32'(hold_exp[i]));
      check("hold_valid", 32'(ifa.x_valid), 32'(!hold_pat[i]));
      check("hold_busy", 32'(ifa.busy), 32'd1);
      check("hold_last", 32'(ifa.last), 32'(i == 10));
      check("hold_ready", 32'(ifa.din_ready), 32'(i == 10));
      tick();
    end
    ifa.hold = 1'b0;
    #1;
    check("hold_end_busy", 32'(ifa.busy), 32'd0);

    // Hold in IDLE does not block accept; then reset mid-word
    ifa.hold = 1'b1; ifa.din = 8'hFF; ifa.din_valid = 1'b1;
    #1;
    check("idle_hold_ready", 32'(ifa.din_ready), 32'd1);
    tick();
    ifa.hold = 1'b0; ifa.din_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      $display("[TB] ff bit %0d x_out=%0b x_valid=%0b", i, ifa.x_out, ifa.x_valid);
      check("ff_xout", 32'(ifa.x_out), 32'd1);
      check("ff_valid", 32'(ifa.x_valid), 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    $display("[TB] after mid-word reset x_out=%0b x_valid=%0b busy=%0b", ifa.x_out, ifa.x_valid, ifa.busy);
    check("mrst_xout", 32'(ifa.x_out), 32'd1);
    check("mrst_valid", 32'(ifa.x_valid), 32'd0);
    check("mrst_busy", 32'(ifa.busy), 32'd0);
    check("mrst_last", 32'(ifa.last), 32'd0);
    check("mrst_ready", 32'(ifa.din_ready), 32'd1);

    w0 = 8'h81;
    ifa.din = w0; ifa.din_valid = 1'b1;
    tick();
    ifa.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      $display("[TB] post-reset bit %0d x_out=%0b last=%0b", i, ifa.x_out, ifa.last);
      check("prst_xout", 32'(ifa.x_out), 32'(w0[7-i]));
      check("prst_valid", 32'(ifa.x_valid), 32'd1);
      check("prst_last", 32'(ifa.last), 32'(i == 7));
      tick();
    end
    #1;
    check("prst_end_busy", 32'(ifa.busy), 32'd0);

    // LSB-first, WIDTH=4, idle level 0
    ifb.din = 4'b0001; ifb.din_valid = 1'b1;
    tick();
    ifb.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      $display("[TB] lsb bit %0d x_out=%0b last=%0b", i, ifb.x_out, ifb.last);
      check("lsb_xout", 32'(ifb.x_out), 32'(i == 0));
      check("lsb_valid", 32'(ifb.x_valid), 32'd1);
      check("lsb_last", 32'(ifb.last), 32'(i == 3));
      tick();
    end
    #1;
    check("lsb_end_xout", 32'(ifb.x_out), 32'd0);
    check("lsb_end_busy", 32'(ifb.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
